pwm_fade_ctrl: RTL and testbench



---
 rtl/pwm_fade_ctrl.sv | 107 ++++++++++
 tb/tb_pwm_fade_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for a PWM core; steps duty on period boundaries.
// Optional abort support is enabled by defining PWM_FADE_ABORT_EN.
module pwm_fade_ctrl #(
  parameter int WIDTH  = 8,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_target,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              period_end,
  input  logic              abort,
  output logic [WIDTH-1:0]  duty,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  tgt;
  logic [RATE_W-1:0] rate;
  logic [RATE_W-1:0] pcnt;

  logic              hs;
  logic              up;
  logic              hit;
  logic              kill;
  logic [WIDTH-1:0]  nxt;

  assign hs  = cfg_valid & cfg_ready;
  assign up  = tgt > duty;
  assign hit = pcnt == rate;
  // Only used in RAMP, where tgt != duty, so no wrap can occur.
  assign nxt = up ? duty + 1'b1 : duty - 1'b1;

`ifdef PWM_FADE_ABORT_EN
  assign kill = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= '0;
      tgt       <= '0;
      rate      <= '0;
      pcnt      <= '0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            tgt  <= cfg_target;
            rate <= cfg_rate;
            pcnt <= '0;
            if (cfg_target == duty) begin
              done <= 1'b1;
            end else begin
              state     <= RAMP;
              busy      <= 1'b1;
              cfg_ready <= 1'b0;
            end
          end
        end
        RAMP: begin
          if (kill) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            pcnt      <= '0;
          end else if (period_end) begin
            if (hit) begin
              duty <= nxt;
              pcnt <= '0;
              if (nxt == tgt) begin
                state     <= IDLE;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
                done      <= 1'b1;
              end
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Table-driven bench for pwm_fade_ctrl with an expected-output queue.
// Covers both PWM_FADE_ABORT_EN builds.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_target;
  logic [7:0] cfg_rate;
  logic       period_end;
  logic       abort;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.WIDTH(8), .RATE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_target (cfg_target),
    .cfg_rate   (cfg_rate),
    .period_end (period_end),
    .abort      (abort),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic       rst;
    logic       cv;
    logic [7:0] tg;
    logic [7:0] rt;
    logic       pe;
    logic       ab;
    logic [7:0] duty;
    logic       busy;
    logic       rdy;
    logic       done;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] duty;
    logic       busy;
    logic       rdy;
    logic       done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic r, input logic cv, input int tg, input int rt,
    input logic pe, input logic ab,
    input int d, input logic b, input logic y, input logic dn);
    vec_t v;
    v.rst  = r;
    v.cv   = cv;
    v.tg   = 8'(tg);
    v.rt   = 8'(rt);
    v.pe   = pe;
    v.ab   = ab;
    v.duty = 8'(d);
    v.busy = b;
    v.rdy  = y;
    v.done = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    rst        = v.rst;
    cfg_valid  = v.cv;
    cfg_target = v.tg;
    cfg_rate   = v.rt;
    period_end = v.pe;
    abort      = v.ab;
    sb.push_back('{nm, v.duty, v.busy, v.rdy, v.done});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".duty"}, int'(duty), int'(e.duty));
      chk({e.name, ".busy"}, int'(busy), int'(e.busy));
      chk({e.name, ".rdy"}, int'(cfg_ready), int'(e.rdy));
      chk({e.name, ".done"}, int'(done), int'(e.done));
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_target = '0;
    cfg_rate   = '0;
    period_end = 1'b0;
    abort      = 1'b0;

    // reset and idle
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    // up ramp 0 -> 4, rate 0
    tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 1, 0));
    // up ramp 4 -> 10
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 4, 1, 0, 0));
    for (int d = 5; d < 10; d++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, d, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 10, 0, 1, 1));
    // down ramp 10 -> 8 at rate 2, competing command held high
    tbl.push_back(mk(0, 1, 8, 2, 0, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 8, 0, 1, 1));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 8, 1, 0, 0));
    for (int d = 7; d > 3; d--)
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, d, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 1, 1));
    // 3 -> 5, then equal-target command
    tbl.push_back(mk(0, 1, 5, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 1, 1));
    tbl.push_back(mk(0, 1, 5, 7, 0, 0, 5, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 1, 0));
    // abort in IDLE has no effect on acceptance
    tbl.push_back(mk(0, 1, 6, 0, 0, 1, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 6, 0, 1, 1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("tbl%0d", i));

    // abort coincident with the third pulse of a 0 -> 200 ramp
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "ab_rst");
    apply(mk(0, 1, 200, 0, 0, 0, 0, 1, 0, 0), "ab_cmd");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0), "ab_p1");
    apply(mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0), "ab_p2");
`ifdef PWM_FADE_ABORT_EN
    apply(mk(0, 0, 0, 0, 1, 1, 2, 0, 1, 0), "ab_hit");
    apply(mk(0, 0, 0, 0, 1, 0, 2, 0, 1, 0), "ab_hold");
    apply(mk(0, 0, 0, 0, 1, 0, 2, 0, 1, 0), "ab_hold2");
`else
    apply(mk(0, 0, 0, 0, 1, 1, 3, 1, 0, 0), "ab_hit");
    for (int d = 4; d <= 200; d++)
      apply(mk(0, 0, 0, 0, 1, 0, d, d != 200, d == 200, d == 200),
            $sformatf("ab_on%0d", d));
    apply(mk(0, 0, 0, 0, 0, 0, 200, 0, 1, 0), "ab_end");
`endif

    // reset in the middle of a 0 -> 50 ramp
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mr_rst0");
    apply(mk(0, 1, 50, 0, 0, 0, 0, 1, 0, 0), "mr_cmd");
    for (int d = 1; d <= 20; d++)
      apply(mk(0, 0, 0, 0, 1, 0, d, 1, 0, 0), $sformatf("mr_p%0d", d));
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0), "mr_rst");
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0), "mr_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
